// File: rtl/board_scheduler_pkg.sv
// Shared types for the snake board scheduler: object codes, scheduler states,
// default geometry and the raster cell-index helper.
package board_scheduler_pkg;

  localparam int GRID_W_DEF        = 16;
  localparam int GRID_H_DEF        = 12;
  localparam int FRAME_TIMEOUT_DEF = 2**20;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    BODY   = 3'd1,
    HEAD   = 3'd2,
    APPLE  = 3'd3,
    BORDER = 3'd4
  } obj_t;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_RENDER = 2'd2
  } sched_state_t;

  // Raster index y*w+x; fits 8 bits for any board of up to 256 cells.
  function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y,
                                            input int w);
    return 8'(int'(y) * w + int'(x));
  endfunction

  // Codes 5-7 carry no object and are stored as EMPTY.
  function automatic obj_t norm_code(input logic [2:0] c);
    return (c > 3'd4) ? EMPTY : obj_t'(c);
  endfunction

endpackage

// File: rtl/board_scheduler_if.sv
// Game-logic write port of the board scheduler.
// Handshake: wr_req is held with wr_x/wr_y/wr_code stable until wr_ack; wr_ack is a
// one-cycle pulse marking the retiring edge, wr_err rides on it for out-of-range cells.
interface board_scheduler_if;
  logic       wr_req;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic [2:0] wr_code;
  logic       wr_ack;
  logic       wr_err;

  modport master (output wr_req, wr_x, wr_y, wr_code, input  wr_ack, wr_err);
  modport slave  (input  wr_req, wr_x, wr_y, wr_code, output wr_ack, wr_err);
endinterface

// File: rtl/board_scheduler_cell_ram.sv
// Board register file: one write port, one registered read port (old data on
// collision) and a combinational peek used to detect value-changing writes.
module cell_ram
  import board_scheduler_pkg::*;
#(
  parameter int DEPTH = GRID_W_DEF * GRID_H_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wr_addr,
  input  obj_t       wr_data,
  input  logic [7:0] peek_addr,
  output obj_t       peek_data,
  input  logic [7:0] rd_addr,
  output obj_t       rd_data
);

  obj_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && int'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)                      rd_data <= EMPTY;
    else if (int'(rd_addr) < DEPTH) rd_data <= mem[rd_addr];
    else                            rd_data <= EMPTY;
  end

  assign peek_data = (int'(peek_addr) < DEPTH) ? mem[peek_addr] : EMPTY;

endmodule

// File: rtl/board_scheduler.sv
// Owns the snake board and sequences redraws: CLEAR sweeps the border ring in,
// IDLE serves writes and starts frames when dirty, RENDER holds writes off.
module board_scheduler
  import board_scheduler_pkg::*;
#(
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF,
  parameter int FRAME_TIMEOUT = FRAME_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  board_scheduler_if.slave    wr,
  input  logic                clear_req,
  input  logic [3:0]          rd_x,
  input  logic [3:0]          rd_y,
  output logic                snakeBody,
  output logic                snakeHead,
  output logic                apple,
  output logic                border,
  output logic                redraw,
  input  logic                frame_done,
  output logic                frame_active,
  output logic                busy,
  output sched_state_t        dbg_state
);

  localparam int               CELLS  = GRID_W * GRID_H;
  localparam int               TW     = $clog2(FRAME_TIMEOUT);
  localparam logic [3:0]       LAST_X = 4'(GRID_W - 1);
  localparam logic [3:0]       LAST_Y = 4'(GRID_H - 1);
  localparam logic [TW-1:0]    LAST_T = TW'(FRAME_TIMEOUT - 1);

  sched_state_t  state;
  logic [3:0]    sweep_x, sweep_y;
  logic          dirty;
  logic [TW-1:0] tcnt;
  logic          rd_ok_q;

  obj_t          wr_code_n, wr_old, rd_code, ram_wdata;
  logic          wr_ok, wr_take, wr_change, sweep_edge, ram_we;
  logic [7:0]    ram_waddr, peek_addr, rd_addr;

  assign wr_code_n  = norm_code(wr.wr_code);
  assign wr_ok      = int'(wr.wr_x) < GRID_W && int'(wr.wr_y) < GRID_H;
  assign peek_addr  = cell_index(wr.wr_x, wr.wr_y, GRID_W);
  assign rd_addr    = cell_index(rd_x, rd_y, GRID_W);
  assign sweep_edge = sweep_x == 4'd0 || sweep_x == LAST_X ||
                      sweep_y == 4'd0 || sweep_y == LAST_Y;
  // The ack cycle itself never takes a second write, so the requester can drop
  // wr_req on the cycle after it sees wr_ack.
  assign wr_take    = state == S_IDLE && !clear_req && wr.wr_req && !wr.wr_ack;
  assign wr_change  = wr_ok && wr_code_n != wr_old;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = peek_addr;
    ram_wdata = wr_code_n;
    if (state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cell_index(sweep_x, sweep_y, GRID_W);
      ram_wdata = sweep_edge ? BORDER : EMPTY;
    end else if (wr_take && wr_change) begin
      ram_we    = 1'b1;
    end
  end

  cell_ram #(.DEPTH(CELLS)) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we        (ram_we),
    .wr_addr   (ram_waddr),
    .wr_data   (ram_wdata),
    .peek_addr (peek_addr),
    .peek_data (wr_old),
    .rd_addr   (rd_addr),
    .rd_data   (rd_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLEAR;
      sweep_x   <= '0;
      sweep_y   <= '0;
      dirty     <= 1'b0;
      tcnt      <= '0;
      wr.wr_ack <= 1'b0;
      wr.wr_err <= 1'b0;
      redraw    <= 1'b0;
    end else begin
      wr.wr_ack <= 1'b0;
      wr.wr_err <= 1'b0;
      redraw    <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (sweep_x == LAST_X) begin
            sweep_x <= '0;
            if (sweep_y == LAST_Y) begin
              sweep_y <= '0;
              dirty   <= 1'b1;
              state   <= S_IDLE;
            end else begin
              sweep_y <= sweep_y + 4'd1;
            end
          end else begin
            sweep_x <= sweep_x + 4'd1;
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            state <= S_CLEAR;
          end else if (wr_take) begin
            wr.wr_ack <= 1'b1;
            wr.wr_err <= !wr_ok;
            if (wr_change) dirty <= 1'b1;
          end else if (dirty) begin
            redraw <= 1'b1;
            dirty  <= 1'b0;
            tcnt   <= '0;
            state  <= S_RENDER;
          end
        end
        S_RENDER: begin
          if (frame_done) begin
            state <= S_IDLE;
          end else if (tcnt == LAST_T) begin
            // The frame may have been lost; redraw again once back in IDLE.
            state <= S_IDLE;
            dirty <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_ok_q <= 1'b0;
    else       rd_ok_q <= int'(rd_x) < GRID_W && int'(rd_y) < GRID_H;
  end

  assign snakeBody    = rd_ok_q && rd_code == BODY;
  assign snakeHead    = rd_ok_q && rd_code == HEAD;
  assign apple        = rd_ok_q && rd_code == APPLE;
  assign border       = rd_ok_q && rd_code == BORDER;
  assign frame_active = state == S_RENDER;
  assign busy         = state == S_CLEAR;
  assign dbg_state    = state;

endmodule

// File: tb/tb_board_scheduler.sv
// Self-checking bench for board_scheduler: directed sequences, a read-vector table,
// and randomized writes checked against a board model.
module tb_board_scheduler;
  import board_scheduler_pkg::*;

  localparam int T_OUT = 64;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] flags;
  } rd_vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear_req = 1'b0;
  logic         frame_done = 1'b0;
  logic [3:0]   rd_x = '0;
  logic [3:0]   rd_y = '0;
  logic         snakeBody, snakeHead, apple, border, redraw, frame_active, busy;
  sched_state_t dbg_state;

  board_scheduler_if wr_if ();

  board_scheduler #(.GRID_W(16), .GRID_H(12), .FRAME_TIMEOUT(T_OUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr_if),
    .clear_req    (clear_req),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .snakeBody    (snakeBody),
    .snakeHead    (snakeHead),
    .apple        (apple),
    .border       (border),
    .redraw       (redraw),
    .frame_done   (frame_done),
    .frame_active (frame_active),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  int redraw_cnt = 0;
  int mdl [16][16];
  logic [3:0] exp_q [$];

  always @(negedge clk) if (redraw) redraw_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_of(input int code);
    case (code)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0010;
      4:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] cur_flags();
    return {snakeBody, snakeHead, apple, border};
  endfunction

  task automatic read_chk(input logic [3:0] x, input logic [3:0] y, input logic [3:0] exp,
                          input string name);
    rd_x = x;
    rd_y = y;
    step();
    check(name, cur_flags(), exp);
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [2:0] code,
                          input bit auto_fd, input int budget,
                          output int waited, output bit acked, output bit err);
    wr_if.wr_req  = 1'b1;
    wr_if.wr_x    = x;
    wr_if.wr_y    = y;
    wr_if.wr_code = code;
    waited = 0;
    acked  = 1'b0;
    err    = 1'b0;
    for (int i = 0; i < budget && !acked; i++) begin
      if (auto_fd) frame_done = frame_active && ($urandom_range(0, 3) == 0);
      step();
      waited++;
      if (wr_if.wr_ack) begin
        acked = 1'b1;
        err   = wr_if.wr_err;
      end
    end
    wr_if.wr_req = 1'b0;
    frame_done   = 1'b0;
  endtask

  task automatic model_clear();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        mdl[x][y] = (y < 12 && (x == 0 || x == 15 || y == 0 || y == 11)) ? 4 : 0;
  endtask

  rd_vec_t vecs [10];

  initial begin
    int   n, rc0, waited, acks;
    bit   acked, err;
    logic [3:0] rx, ry;
    logic [2:0] rc;

    vecs[0] = '{4'd0,  4'd0,  4'b0001};
    vecs[1] = '{4'd5,  4'd5,  4'b0000};
    vecs[2] = '{4'd15, 4'd11, 4'b0001};
    vecs[3] = '{4'd15, 4'd12, 4'b0000};
    vecs[4] = '{4'd0,  4'd11, 4'b0001};
    vecs[5] = '{4'd7,  4'd0,  4'b0001};
    vecs[6] = '{4'd14, 4'd10, 4'b0000};
    vecs[7] = '{4'd3,  4'd15, 4'b0000};
    vecs[8] = '{4'd15, 4'd5,  4'b0001};
    vecs[9] = '{4'd1,  4'd1,  4'b0000};

    wr_if.wr_req  = 1'b0;
    wr_if.wr_x    = '0;
    wr_if.wr_y    = '0;
    wr_if.wr_code = '0;

    // reset state
    reset = 1'b1;
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_state", dbg_state, S_CLEAR);
    check("rst_pulses", {wr_if.wr_ack, wr_if.wr_err, redraw, frame_active}, 0);
    check("rst_flags", cur_flags(), 0);
    reset = 1'b0;

    // 1: initial sweep, first redraw, read table
    n = 0;
    while (busy && n < 1000) begin step(); n++; end
    check("t1_busy_cycles", n, 192);
    check("t1_no_early_redraw", redraw, 0);
    step();
    check("t1_redraw", redraw, 1);
    check("t1_active", frame_active, 1);
    step();
    check("t1_redraw_once", redraw, 0);
    for (int i = 0; i < 10; i++) read_chk(vecs[i].x, vecs[i].y, vecs[i].flags, "t1_table");
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check("t1_frame_end", frame_active, 0);

    // 2: write HEAD at (5,4)
    do_write(4'd5, 4'd4, 3'd2, 1'b0, 10, waited, acked, err);
    check("t2_ack_latency", waited, 1);
    check("t2_err", err, 0);
    rd_x = 4'd5;
    rd_y = 4'd4;
    step();
    check("t2_head", cur_flags(), 4'b0100);
    check("t2_redraw", redraw, 1);
    step();
    check("t2_redraw_once", redraw, 0);
    check("t2_active", frame_active, 1);

    // 3: write held off while rendering
    wr_if.wr_req  = 1'b1;
    wr_if.wr_x    = 4'd7;
    wr_if.wr_y    = 4'd4;
    wr_if.wr_code = 3'd3;
    acks = 0;
    for (int i = 0; i < 4; i++) begin step(); acks += int'(wr_if.wr_ack); end
    check("t3_no_ack_render", acks, 0);
    check("t3_still_active", frame_active, 1);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check("t3_idle_no_ack", {frame_active, wr_if.wr_ack}, 0);
    step();
    check("t3_ack_after_idle", wr_if.wr_ack, 1);
    wr_if.wr_req = 1'b0;
    step();
    check("t3_redraw", redraw, 1);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;

    // 4: identical rewrite does not redraw
    rc0 = redraw_cnt;
    do_write(4'd5, 4'd4, 3'd2, 1'b0, 10, waited, acked, err);
    check("t4_ack", {acked, err}, 2'b10);
    repeat (6) step();
    check("t4_no_redraw", redraw_cnt - rc0, 0);
    check("t4_idle", frame_active, 0);
    read_chk(4'd7, 4'd4, 4'b0010, "t4_apple");

    // 5: out-of-range write; code 6 onto EMPTY stores EMPTY
    rc0 = redraw_cnt;
    do_write(4'd3, 4'd12, 3'd2, 1'b0, 10, waited, acked, err);
    check("t5_oor_latency", waited, 1);
    check("t5_oor_err", {acked, err}, 2'b11);
    do_write(4'd6, 4'd6, 3'd6, 1'b0, 10, waited, acked, err);
    check("t5_code6_ack", {acked, err}, 2'b10);
    repeat (5) step();
    check("t5_no_redraw", redraw_cnt - rc0, 0);
    read_chk(4'd3, 4'd11, 4'b0001, "t5_border_kept");
    read_chk(4'd15, 4'd12, 4'b0000, "t5_read_oor");
    read_chk(4'd6, 4'd6, 4'b0000, "t5_code6_empty");
    read_chk(4'd5, 4'd4, 4'b0100, "t5_head_kept");

    // 6: stray frame_done, clear beats write, timeout
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check("t6_stray_done", dbg_state, S_IDLE);
    wr_if.wr_req  = 1'b1;
    wr_if.wr_x    = 4'd2;
    wr_if.wr_y    = 4'd2;
    wr_if.wr_code = 3'd1;
    clear_req     = 1'b1;
    step();
    clear_req = 1'b0;
    check("t6_clear_first", {busy, wr_if.wr_ack}, 2'b10);
    n = 0;
    while (!wr_if.wr_ack && n < 400) begin step(); n++; end
    check("t6_ack_wait", n, 193);
    check("t6_not_busy", busy, 0);
    wr_if.wr_req = 1'b0;
    step();
    check("t6_redraw", redraw, 1);
    n = 0;
    while (frame_active && n < 200) begin step(); n++; end
    check("t6_timeout_cycles", n, T_OUT);
    step();
    check("t6_redraw_again", redraw, 1);
    read_chk(4'd2, 4'd2, 4'b1000, "t6_body");
    read_chk(4'd5, 4'd4, 4'b0000, "t6_head_cleared");
    read_chk(4'd7, 4'd4, 4'b0000, "t6_apple_cleared");
    read_chk(4'd0, 4'd5, 4'b0001, "t6_border");
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;

    // reset in the middle of a sweep restarts it from cell 0
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (50) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_state", dbg_state, S_CLEAR);
    n = 0;
    while (busy && n < 400) begin step(); n++; end
    check("mid_rst_busy_cycles", n, 192);

    // randomized writes against the board model
    model_clear();
    for (int i = 0; i < 40; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 13));
      rc = 3'($urandom_range(0, 7));
      do_write(rx, ry, rc, 1'b1, 300, waited, acked, err);
      check("rnd_acked", acked, 1);
      check("rnd_err", err, (ry >= 4'd12) ? 1 : 0);
      if (ry < 4'd12) mdl[rx][ry] = (rc > 3'd4) ? 0 : int'(rc);
    end
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        rd_x = 4'(x);
        rd_y = 4'(y);
        exp_q.push_back(flags_of(mdl[x][y]));
        step();
        check("rnd_cell", cur_flags(), exp_q.pop_front());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
